// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the scoreboarded register file.
package regfile_pkg;

    localparam int DEF_XLEN  = 32;
    localparam int DEF_NREGS = 32;
    localparam int DEF_NRD   = 2;
    localparam int DEF_NWR   = 2;

    // Address width needed to select one of nregs registers (at least one bit).
    function automatic int addr_width(input int nregs);
        return (nregs < 2) ? 1 : $clog2(nregs);
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: tracks which registers still wait for an outstanding producer.
// Priority on each edge: writes clear, then flush clears everything, otherwise an issue sets.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS = DEF_NREGS,
    parameter int NWR   = DEF_NWR,
    parameter int AW    = addr_width(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NWR-1:0]    wr_en,
    input  logic [NWR*AW-1:0] wr_addr,
    input  logic              iss_en,
    input  logic [AW-1:0]     iss_rd,
    input  logic              flush,
    output logic [NREGS-1:0]  busy_vec
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    // Next busy state: completed writes retire producers, flush wipes all, a new issue marks its destination.
    always_comb begin
        busy_d = busy_q;
        for (int j = 0; j < NWR; j++) begin
            if (wr_en[j]) begin
                busy_d[wr_addr[j*AW +: AW]] = 1'b0;
            end
        end
        if (flush) begin
            busy_d = '0;
        end else if (iss_en && (iss_rd != '0)) begin
            busy_d[iss_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Scoreboard register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;

endmodule

// File: rtl/regfile_sb.sv
// Multi-ported register file with write-to-read bypass and an issue scoreboard.
// Register 0 is hardwired to zero and is never busy.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter  int XLEN  = DEF_XLEN,
    parameter  int NREGS = DEF_NREGS,
    parameter  int NRD   = DEF_NRD,
    parameter  int NWR   = DEF_NWR,
    localparam int AW    = addr_width(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    input  logic                iss_en,
    input  logic [AW-1:0]       iss_rd,
    input  logic                flush,
    output logic [NREGS-1:0]    busy_vec
);

    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];

    // Next storage contents: later write ports overwrite earlier ones, so the highest index wins.
    always_comb begin
        regs_d = regs_q;
        for (int j = 0; j < NWR; j++) begin
            if (wr_en[j] && (wr_addr[j*AW +: AW] != '0)) begin
                regs_d[wr_addr[j*AW +: AW]] = wr_data[j*XLEN +: XLEN];
            end
        end
        regs_d[0] = '0;
    end

    // Storage flops with synchronous active-low reset clearing every register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int r = 0; r < NREGS; r++) begin
                regs_q[r] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0]   ra;
        logic [XLEN-1:0] rdata;
        logic            hit;

        assign ra = rd_addr[i*AW +: AW];

        // Read port: stored value, overridden by the highest-indexed same-cycle write to this address.
        always_comb begin
            rdata = regs_q[ra];
            hit   = 1'b0;
            for (int j = 0; j < NWR; j++) begin
                if (wr_en[j] && (wr_addr[j*AW +: AW] == ra)) begin
                    rdata = wr_data[j*XLEN +: XLEN];
                    hit   = 1'b1;
                end
            end
            if (ra == '0) begin
                rdata = '0;
                hit   = 1'b1;
            end
        end

        assign rd_data[i*XLEN +: XLEN] = rdata;
        assign rd_busy[i]              = busy_vec[ra] & ~hit;
    end

    regfile_scoreboard #(
        .NREGS (NREGS),
        .NWR   (NWR),
        .AW    (AW)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .iss_en   (iss_en),
        .iss_rd   (iss_rd),
        .flush    (flush),
        .busy_vec (busy_vec)
    );

endmodule
